// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PrID storage, mfc0/mtc0 access and
// interrupt/exception request generation for the fetch stage.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL = 32'h1817_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im;
    logic [5:0]  ip;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;

    logic        int_pend;
    logic        exc_pend;
    logic        sr_we;
    logic        epc_we;
    logic [31:0] pc_al;
    logic [31:0] victim_pc;
    logic        unused_pc_lsbs;

    assign int_pend  = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend  = (ExcCode_M != 5'd0) & ~exl;
    // Gated by reset so the fetch stage never redirects while the core is held.
    assign IntReq    = reset & (int_pend | exc_pend);

    // The mtc0 in M is the victim when a request fires, so it must not commit.
    assign sr_we     = We & (A2 == 5'd12) & ~IntReq;
    assign epc_we    = We & (A2 == 5'd14) & ~IntReq;

    assign pc_al          = {PC_M[31:2], 2'b00};
    assign victim_pc      = BD_M ? (pc_al - 32'd4) : pc_al;
    assign unused_pc_lsbs = ^PC_M[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc_q    <= '0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                bd       <= BD_M;
                exc_code <= int_pend ? 5'd0 : ExcCode_M;
                epc_q    <= victim_pc;
            end else begin
                if (EXLClr) begin
                    exl <= 1'b0;
                end else if (sr_we) begin
                    exl <= DIn[1];
                end
                if (sr_we) begin
                    im <= DIn[15:10];
                    ie <= DIn[0];
                end
                if (epc_we) begin
                    epc_q <= {DIn[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            5'd12:   DOut = {16'h0000, im, 8'h00, exl, ie};
            5'd13:   DOut = {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID_VAL;
            default: DOut = '0;
        endcase
    end

    assign EPC = epc_q;

endmodule
